// File: rtl/pio_gpio_if.sv
// Register bus between the interconnect and the pio_gpio slave.
// Single-cycle writes, reads answered one cycle after the read strobe.
interface pio_gpio_if;
    logic        bus_wen;
    logic        bus_ren;
    logic [1:0]  bus_adr;
    logic [31:0] bus_wdt;
    logic [31:0] bus_rdt;

    modport master (
        output bus_wen,
        output bus_ren,
        output bus_adr,
        output bus_wdt,
        input  bus_rdt
    );

    modport slave (
        input  bus_wen,
        input  bus_ren,
        input  bus_adr,
        input  bus_wdt,
        output bus_rdt
    );
endinterface

// File: rtl/pio_gpio.sv
// Debounced GPIO: NI synchronised inputs, NO registered outputs, edge interrupts behind 4 registers.
// Build option PIO_DEBOUNCE_EN: when defined, per-channel debounce counters filter the inputs.
module pio_gpio #(
    parameter int unsigned     NI       = 4,
    parameter int unsigned     NO       = 2,
    parameter int unsigned     DEBOUNCE = 32768,
    parameter logic [NI-1:0]   IRQ_RISE = {NI{1'b1}},
    parameter logic [NI-1:0]   IRQ_FALL = {NI{1'b0}},
    parameter logic [NO-1:0]   OUT_RST  = {NO{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    pio_gpio_if.slave     bus,
    input  logic [NI-1:0] pio_i,
    output logic [NO-1:0] pio_o,
    output logic          irq
);

    localparam logic [1:0] ADR_IN     = 2'd0;
    localparam logic [1:0] ADR_OUT    = 2'd1;
    localparam logic [1:0] ADR_MASK   = 2'd2;
    localparam logic [1:0] ADR_STATUS = 2'd3;

    if (NI < 1 || NI > 32) begin : g_bad_ni
        $error("pio_gpio: NI must be in 1..32");
    end
    if (NO < 1 || NO > 32) begin : g_bad_no
        $error("pio_gpio: NO must be in 1..32");
    end
    if (DEBOUNCE < 1) begin : g_bad_debounce
        $error("pio_gpio: DEBOUNCE must be at least 1");
    end

    logic [NI-1:0] sync1_q, sync2_q;
    logic [NI-1:0] stable_q, stable_d;
    logic [NI-1:0] stable_prev_q;
    logic [NO-1:0] out_q, out_d;
    logic [NI-1:0] mask_q, mask_d;
    logic [NI-1:0] status_q, status_d;
    logic [31:0]   rdt_q, rdt_d;
    logic [31:0]   rd_mux;
    logic [NI-1:0] evt;
    logic          wr_out, wr_mask, wr_status;
    logic          unused_wdt;

`ifdef PIO_DEBOUNCE_EN
    localparam int unsigned     CW     = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]   CNT_TC = CW'(DEBOUNCE - 1);

    logic [NI-1:0][CW-1:0] cnt_q, cnt_d;

    // Count cycles of disagreement; the stable bit flips on the cycle the count would reach DEBOUNCE.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        for (int i = 0; i < NI; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_TC) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        stable_d = sync2_q;
    end
`endif

    assign evt = (stable_q & ~stable_prev_q & IRQ_RISE)
               | (~stable_q & stable_prev_q & IRQ_FALL);

    assign wr_out    = bus.bus_wen && (bus.bus_adr == ADR_OUT);
    assign wr_mask   = bus.bus_wen && (bus.bus_adr == ADR_MASK);
    assign wr_status = bus.bus_wen && (bus.bus_adr == ADR_STATUS);

    always_comb begin
        out_d    = out_q;
        mask_d   = mask_q;
        status_d = status_q;
        if (wr_out) begin
            out_d = bus.bus_wdt[NO-1:0];
        end
        if (wr_mask) begin
            mask_d = bus.bus_wdt[NI-1:0];
        end
        if (wr_status) begin
            status_d = status_q & ~bus.bus_wdt[NI-1:0];
        end
        // A new event overrides a same-cycle clear.
        status_d = status_d | evt;
    end

    // Read mux works from current register values, so a same-cycle write is not visible.
    always_comb begin
        rd_mux = '0;
        case (bus.bus_adr)
            ADR_IN:   rd_mux = 32'(stable_q);
            ADR_OUT:  rd_mux = 32'(out_q);
            ADR_MASK: rd_mux = 32'(mask_q);
            default:  rd_mux = 32'(status_q);
        endcase
    end

    always_comb begin
        rdt_d = rdt_q;
        if (bus.bus_ren) begin
            rdt_d = rd_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            out_q         <= OUT_RST;
            mask_q        <= '0;
            status_q      <= '0;
            rdt_q         <= '0;
        end else begin
            sync1_q       <= pio_i;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            out_q         <= out_d;
            mask_q        <= mask_d;
            status_q      <= status_d;
            rdt_q         <= rdt_d;
        end
    end

    assign unused_wdt  = ^bus.bus_wdt;
    assign bus.bus_rdt = rdt_q;
    assign pio_o       = out_q;
    assign irq         = |(status_q & mask_q);

endmodule

// File: tb/tb_pio_gpio.sv
// Directed bench for pio_gpio (NI=4, NO=2, DEBOUNCE=4); timing expectations follow PIO_DEBOUNCE_EN.
module tb_pio_gpio;

    localparam int unsigned DEB = 4;
`ifdef PIO_DEBOUNCE_EN
    localparam int          LAT      = DEB + 1;
    localparam logic [31:0] GLITCH_ST = 32'h0;
    localparam logic [31:0] PULSE_IN  = 32'hD;
`else
    localparam int          LAT      = 2;
    localparam logic [31:0] GLITCH_ST = 32'h2;
    localparam logic [31:0] PULSE_IN  = 32'hF;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] pio_i;
    logic [1:0] pio_o;
    logic       irq;
    logic [31:0] rd;
    int n_cmp;
    int n_err;

    pio_gpio_if bus_if ();

    pio_gpio #(
        .NI       (4),
        .NO       (2),
        .DEBOUNCE (DEB),
        .IRQ_RISE (4'b1101),
        .IRQ_FALL (4'b0010),
        .OUT_RST  (2'b10)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_if),
        .pio_i (pio_i),
        .pio_o (pio_o),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_if.bus_ren = 1'b1;
        bus_if.bus_adr = a;
        @(negedge clk);
        bus_if.bus_ren = 1'b0;
        d = bus_if.bus_rdt;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.bus_wen = 1'b1;
        bus_if.bus_adr = a;
        bus_if.bus_wdt = d;
        @(negedge clk);
        bus_if.bus_wen = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        pio_i = 4'h0;
        bus_if.bus_wen = 1'b0;
        bus_if.bus_ren = 1'b0;
        bus_if.bus_adr = 2'd0;
        bus_if.bus_wdt = 32'h0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_pio_o", 32'(pio_o), 32'h2);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdt", bus_if.bus_rdt, 32'h0);
        rst = 1'b0;
        rd_chk("rst_in", 2'd0, 32'h0);
        rd_chk("rst_out", 2'd1, 32'h2);
        rd_chk("rst_mask", 2'd2, 32'h0);
        rd_chk("rst_status", 2'd3, 32'h0);

        // OUT and MASK writes, upper bits ignored
        bus_write(2'd1, 32'hFFFF_FFFD);
        chk("out_pio_o", 32'(pio_o), 32'h1);
        rd_chk("out_rd", 2'd1, 32'h1);
        bus_write(2'd2, 32'h0000_00F1);
        rd_chk("mask_rd", 2'd2, 32'h1);

        // ch0 rise: exact latency of IN, STATUS and irq
        pio_i[0] = 1'b1;
        repeat (LAT) @(negedge clk);
        rd_chk("rise_in_before", 2'd0, 32'h0);
        chk("rise_irq_before", 32'(irq), 32'h0);
        rd_chk("rise_in_after", 2'd0, 32'h1);
        chk("rise_irq_after", 32'(irq), 32'h1);
        rd_chk("rise_status", 2'd3, 32'h1);
        bus_write(2'd3, 32'h1);
        chk("w1c_irq", 32'(irq), 32'h0);
        rd_chk("w1c_status", 2'd3, 32'h0);

        // 3-cycle glitch on ch1
        pio_i[1] = 1'b1;
        repeat (3) @(negedge clk);
        pio_i[1] = 1'b0;
        repeat (8) @(negedge clk);
        rd_chk("glitch_in", 2'd0, 32'h1);
        rd_chk("glitch_status", 2'd3, GLITCH_ST);
        bus_write(2'd3, 32'hF);

        // ch1: rise disabled, fall enabled
        pio_i[1] = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        rd_chk("ch1_rise_in", 2'd0, 32'h3);
        rd_chk("ch1_rise_status", 2'd3, 32'h0);
        pio_i[1] = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        rd_chk("ch1_fall_in", 2'd0, 32'h1);
        rd_chk("ch1_fall_status", 2'd3, 32'h2);
        chk("ch1_fall_irq_masked", 32'(irq), 32'h0);
        bus_write(2'd2, 32'h3);
        chk("ch1_irq_unmasked", 32'(irq), 32'h1);
        bus_write(2'd3, 32'h2);
        chk("ch1_irq_cleared", 32'(irq), 32'h0);

        // event recorded with MASK=0
        bus_write(2'd2, 32'h0);
        pio_i[2] = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        rd_chk("nomask_status", 2'd3, 32'h4);
        chk("nomask_irq", 32'(irq), 32'h0);

        // clear of STATUS[0] on the same edge as a new ch0 event
        pio_i[0] = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        rd_chk("ch0_fall_noevt", 2'd3, 32'h4);
        pio_i[0] = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        bus_write(2'd3, 32'h5);
        rd_chk("collision_status", 2'd3, 32'h1);
        bus_write(2'd3, 32'h1);
        rd_chk("late_clear_status", 2'd3, 32'h0);

        // same-cycle read and write of OUT returns the old value; rdt holds
        bus_if.bus_ren = 1'b1;
        bus_if.bus_wen = 1'b1;
        bus_if.bus_adr = 2'd1;
        bus_if.bus_wdt = 32'h2;
        @(negedge clk);
        bus_if.bus_ren = 1'b0;
        bus_if.bus_wen = 1'b0;
        chk("rdwr_rdt_old", bus_if.bus_rdt, 32'h1);
        chk("rdwr_pio_o_new", 32'(pio_o), 32'h2);
        repeat (3) @(negedge clk);
        chk("rdt_hold", bus_if.bus_rdt, 32'h1);
        bus_write(2'd1, 32'h1);
        rd_chk("out_rd2", 2'd1, 32'h1);

        // reset mid-debounce; inputs held high through reset rise after release
        pio_i[3] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst2_pio_o", 32'(pio_o), 32'h2);
        chk("rst2_irq", 32'(irq), 32'h0);
        chk("rst2_rdt", bus_if.bus_rdt, 32'h0);
        rd_chk("rst2_in_release", 2'd0, 32'h0);
        repeat (LAT + 3) @(negedge clk);
        rd_chk("rst2_in_settled", 2'd0, 32'hD);
        rd_chk("rst2_status", 2'd3, 32'hD);

        // 1-cycle pulse on ch1
        pio_i[1] = 1'b1;
        @(negedge clk);
        pio_i[1] = 1'b0;
        @(negedge clk);
        rd_chk("pulse_in_k1", 2'd0, 32'hD);
        rd_chk("pulse_in_k2", 2'd0, PULSE_IN);
        rd_chk("pulse_in_k3", 2'd0, 32'hD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pio_gpio.md
# pio_gpio

Parametrised debounced general-purpose I/O block for the ecs8 board family and its successors. It replaces hard-wired button, switch and LED pins with N synchronised and debounced inputs and M registered outputs. It adds per-channel edge-triggered interrupts behind a 4-register bus slave. It sits between the board pins (button, switch, rtc_irq_n, led_n) and the system interconnect.

## Interface
- NI, default 4: number of input channels (1..32)
- NO, default 2: number of output channels (1..32)
- DEBOUNCE, default 32768: consecutive stable cycles required to accept an input change (≥1); 1 ms at 32.768 MHz
- IRQ_RISE, default {NI{1'b1}}: per-channel enable for rising-edge events
- IRQ_FALL, default {NI{1'b0}}: per-channel enable for falling-edge events
- OUT_RST, default {NO{1'b0}}: reset value of the output register

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- bus_wen  in  1  register write strobe
- bus_ren  in  1  register read strobe
- bus_adr  in  2  register index
- bus_wdt  in  32  write data
- bus_rdt  out  32  read data
- pio_i  in  NI  raw asynchronous pin inputs
- pio_o  out  NO  output pins, driven from OUT register
- irq  out  1  level interrupt request

## Operation
- Registers (unused upper bits read 0, writes ignored):
  - 0 IN: debounced state, read-only
  - 1 OUT: read/write, drives pio_o directly
  - 2 MASK: read/write, interrupt enable per channel
  - 3 STATUS: event flags, write-1-to-clear
- Per input channel: 2-FF synchroniser → debounce counter (width clog2(DEBOUNCE+1)) → stable bit.
  - Counter clears whenever the synchronised value equals the stable bit.
  - Otherwise the counter increments each cycle.
  - When it reaches DEBOUNCE, the stable bit takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE cycles never changes IN.
- Event: stable bit 0→1 with IRQ_RISE[i], or stable bit 1→0 with IRQ_FALL[i], sets STATUS[i].
- Events are recorded regardless of MASK.
- irq = |(STATUS & MASK); combinational from the registers, no glitch sources.
- Simultaneous write-1-to-clear and new event on the same bit: the event wins, and the bit stays 1.
- Simultaneous read and write to the same address: read returns the pre-write value.
- Reset values:
  - IN = 0, OUT = OUT_RST, MASK = 0, STATUS = 0
  - Synchronisers and counters 0
  - bus_rdt = 0, irq = 0, pio_o = OUT_RST
- Reset asserted mid-debounce discards the count; no event is generated by reset release.
- An input held high through reset produces a rising event once debounced after release.

## Timing
- Write: register updates on the clk edge where bus_wen=1. pio_o changes on that same edge, with 0 cycles extra latency.
- Read: bus_rdt is valid the cycle after bus_ren=1 (1-cycle latency). It holds its value until the next read; no wait states.
- Input path: pin change first sampled at edge k. The synchroniser output changes at edge k+1. The stable bit/IN changes at edge k+1+DEBOUNCE. STATUS and irq change at edge k+2+DEBOUNCE.
- Counter does not wrap; it saturates by construction because it clears at DEBOUNCE.

## Configuration
- PIO_DEBOUNCE_EN defined: debounce counters instantiated as above.
- PIO_DEBOUNCE_EN undefined: counters removed and DEBOUNCE ignored. Stable bit = synchroniser output delayed one register. IN changes at edge k+2, and STATUS/irq at edge k+3.

## Test plan
- Reset: assert rst 3 cycles with OUT_RST=2'b10 → pio_o=2'b10, irq=0, all reads return 0 except OUT=0x2.
- Debounce: DEBOUNCE=4, raise pio_i[0] and hold → IN reads 0x1 exactly 5 cycles after first sampling. A 3-cycle pulse on pio_i[1] → IN unchanged, STATUS=0.
- Interrupt: MASK=0x1, debounced rise on ch0 → STATUS=0x1, irq=1. Write STATUS=0x1 → irq=0 next cycle. MASK=0 with an event → STATUS set, irq=0.
- Collision: write-1-to-clear of STATUS[0] on the same edge as a new ch0 event → STATUS[0]=1.
- Falling edge: IRQ_FALL=0x2, ch1 debounced 1→0 → STATUS=0x2. Rising on ch1 with IRQ_RISE[1]=0 → no event.
- Macro off: PIO_DEBOUNCE_EN undefined, 1-cycle pulse on pio_i[0] → IN shows the pulse for 1 cycle at k+2.
